// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: one 32-bit column of the 128-bit state per cycle.
// Define INV_SUB_BYTES_FWD_EN to add the fwd input and forward S-box tables.
module inv_sub_bytes_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  // Entry b sits at bits [2047-8b -: 8], i.e. index {~b, 3'b111}.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SUB_BYTES_FWD_EN
  localparam logic [2047:0] FWD_SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
`endif

  state_t       state_reg, state_next;
  logic [127:0] st_reg, st_next;
  logic [1:0]   col_reg, col_next;
  logic [6:0]   col_msb;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
`ifdef INV_SUB_BYTES_FWD_EN
  logic         mode_reg, mode_next;
`endif

  // Column c occupies st[127-32c -: 32]; 127-32c == {~c, 5'b11111}.
  assign col_msb = {~col_reg, 5'b11111};
  assign col_in  = st_reg[col_msb -: 32];

  // Four lookup lanes shared by all columns.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_byte;
      logic [7:0] inv_byte;
      assign lane_byte = col_in[31-8*gi -: 8];
      assign inv_byte  = INV_SBOX_TBL[{~lane_byte, 3'b111} -: 8];
`ifdef INV_SUB_BYTES_FWD_EN
      logic [7:0] fwd_byte;
      assign fwd_byte = FWD_SBOX_TBL[{~lane_byte, 3'b111} -: 8];
      assign col_out[31-8*gi -: 8] = mode_reg ? fwd_byte : inv_byte;
`else
      assign col_out[31-8*gi -: 8] = inv_byte;
`endif
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      col_reg   <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      mode_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      st_reg    <= st_next;
      col_reg   <= col_next;
`ifdef INV_SUB_BYTES_FWD_EN
      mode_reg  <= mode_next;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    st_next    = st_reg;
    col_next   = col_reg;
`ifdef INV_SUB_BYTES_FWD_EN
    mode_next  = mode_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          st_next    = in_state;
          col_next   = 2'd0;
          state_next = SUB;
`ifdef INV_SUB_BYTES_FWD_EN
          mode_next  = fwd;
`endif
        end
      end
      SUB: begin
        st_next[col_msb -: 32] = col_out;
        col_next = col_reg + 2'd1;
        if (col_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg == SUB) || (state_reg == DONE);
    out_state = st_reg;
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq against a GF(2^8)-derived S-box model.
// Fwd-mode checks compile only when INV_SUB_BYTES_FWD_EN is defined.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         fwd_drv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_sub_bytes_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_SUB_BYTES_FWD_EN
    .fwd       (fwd_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from multiplicative inverse plus affine transform; inverse table by inversion.
  task automatic build_tables();
    logic [7:0] iv, s;
    for (int i = 0; i < 256; i++) begin
      iv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (i != 0 && gmul(8'(i), 8'(j)) == 8'h01) iv = 8'(j);
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      fwd_tab[i] = s;
      inv_tab[s] = 8'(i);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic f);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = s[127-8*k -: 8];
      r[127-8*k -: 8] = f ? fwd_tab[b] : inv_tab[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block: accept, scribble inputs during SUB, hold DONE for `hold` cycles, release.
  task automatic run_block(input logic [127:0] s, input logic f, input int hold);
    logic [127:0] exp;
    int lat;
    exp = model(s, f);
    @(negedge clk);
    check("in_ready_idle", 128'(in_ready), 128'd1);
    in_valid = 1'b1; in_state = s; fwd_drv = f;
    @(posedge clk); #1;
    in_valid = 1'b0; in_state = rand128(); fwd_drv = ~f;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      in_state = rand128();
      in_valid = 1'($urandom_range(0, 1));
      fwd_drv  = 1'($urandom_range(0, 1));
    end
    check("latency", 128'(lat), 128'd4);
    check("out_state", out_state, exp);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_state", out_state, exp);
      in_valid = 1'($urandom_range(0, 1));
      in_state = rand128();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_in_ready", 128'(in_ready), 128'd1);
    check("ret_out_valid", 128'(out_valid), 128'd0);
    check("ret_busy", 128'(busy), 128'd0);
    $display("block fwd=%0d in=%h out=%h", f, s, exp);
  endtask

  logic [127:0] bb [3];
  logic [127:0] exp_q [$];
  int acc_cyc [3];

  initial begin
    build_tables();

    // Power-on reset
    #12;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // Known inverse values
    run_block({4{32'h631662f4}}, 1'b0, 0);
    check("known_vals", out_state, {4{32'h00ffabba}});

    // FIPS-197 vector
    run_block(128'h7a9f102789d5f50b2befdd9f3dca4ea7 ^ 128'h0000000000000000_0000200000000000, 1'b0, 0);
    check("fips_vec", out_state, 128'hbd6e7c3df2b5779e0b61216e8b10b689);

    // Reset asserted mid-SUB and mid-DONE
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_state = rand128();
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (t == 0 ? 2 : 5) @(posedge clk);
      #3; rst_n = 1'b0; #1;
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      check("mid_rst_out_state", out_state, 128'd0);
      @(negedge clk); rst_n = 1'b1;
      run_block(rand128(), 1'b0, 0);
    end

    // Backpressure with ignored input pulses
    run_block(rand128(), 1'b0, 10);
    @(posedge clk); #1;
    check("bp_no_capture", 128'(busy), 128'd0);

    // Random blocks with random backpressure
    for (int n = 0; n < 12; n++) run_block(rand128(), 1'b0, int'($urandom_range(0, 3)));

`ifdef INV_SUB_BYTES_FWD_EN
    run_block(128'd0, 1'b1, 0);
    check("fwd_zero", out_state, {16{8'h63}});
    for (int n = 0; n < 4; n++) run_block(rand128(), 1'(n % 2), 1);
`endif

    // Back-to-back throughput
    begin
      int nacc, ndone, cyc;
      logic acc;
      for (int i = 0; i < 3; i++) bb[i] = rand128();
      nacc = 0; ndone = 0; cyc = 0;
      @(negedge clk);
      in_state = bb[0]; in_valid = 1'b1; out_ready = 1'b1; fwd_drv = 1'b0;
      while ((nacc < 3 || ndone < 3) && cyc < 60) begin
        acc = 1'b0;
        if (in_valid && in_ready) begin
          acc_cyc[nacc] = cyc;
          exp_q.push_back(model(in_state, 1'b0));
          nacc++;
          acc = 1'b1;
        end
        if (out_valid && exp_q.size() > 0) begin
          check("b2b_out", out_state, exp_q.pop_front());
          $display("b2b result %0d out=%h", ndone, out_state);
          ndone++;
        end
        @(posedge clk); cyc++;
        @(negedge clk);
        if (acc) begin
          if (nacc < 3) in_state = bb[nacc];
          else in_valid = 1'b0;
        end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b_nacc", 128'(nacc), 128'd3);
      check("b2b_ndone", 128'(ndone), 128'd3);
      check("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
      check("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
